// File: rtl/minisrc_pkg.sv
// minisrc_pkg
// Shared constants for the Mini SRC CPU and its peripherals.
// WORD_WIDTH    : width of the CPU data bus and of every bus-side data word.
// IN_FIFO_DEPTH : default number of entries in the input-port FIFO.
package minisrc_pkg;

  localparam int WORD_WIDTH    = 32;
  localparam int IN_FIFO_DEPTH = 8;

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem
// DEPTH x WIDTH register array used as FIFO storage.
// Ports:
//   clk   : system clock, writes take effect on the rising edge
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, combinational from raddr
// Storage is intentionally not reset; the owning FIFO tracks validity.
module fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/in_port_fifo.sv
// in_port_fifo
// Input-port front end for the Mini SRC CPU. An external device pushes words
// through a valid/ready handshake into a small FIFO; each CPU "in" instruction
// pops one word into a registered output feeding the CPU In.Port path.
// Ports:
//   clk          : system clock, all state updates on the rising edge
//   reset        : synchronous active-high reset
//   dev_data     : word from the external device
//   dev_valid    : device presents dev_data this cycle
//   dev_ready    : FIFO can accept a word this cycle (not full)
//   cpu_rd       : one-cycle pop strobe from the CPU control unit
//   in_port_data : registered word to the CPU In.Port / bus mux
//   data_avail   : FIFO not empty
//   count        : current occupancy, 0..DEPTH
//   underflow    : sticky, set when cpu_rd arrives on an empty FIFO
//   clr_flags    : one-cycle pulse clearing underflow
module in_port_fifo
  import minisrc_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int DEPTH = IN_FIFO_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dev_data,
  input  logic             dev_valid,
  output logic             dev_ready,
  input  logic             cpu_rd,
  output logic [WIDTH-1:0] in_port_data,
  output logic             data_avail,
  output logic [CW-1:0]    count,
  output logic             underflow,
  input  logic             clr_flags
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] rd_word;
  logic             push;
  logic             pop;

  // Status comes only from the registered count, so no input reaches an
  // output combinationally. A pop never frees a slot for a push in the same
  // cycle: dev_ready reflects last cycle's occupancy.
  assign dev_ready  = (count != CW'(DEPTH));
  assign data_avail = (count != '0);
  assign push       = dev_valid && dev_ready;
  assign pop        = cpu_rd && data_avail;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (dev_data),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // The output word is only replaced by a successful pop; an empty read
  // leaves the previous word in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_port_data <= '0;
    end else if (pop) begin
      in_port_data <= rd_word;
    end
  end

  // A new underflow takes priority over a clear arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      underflow <= 1'b0;
    end else if (cpu_rd && !data_avail) begin
      underflow <= 1'b1;
    end else if (clr_flags) begin
      underflow <= 1'b0;
    end
  end

endmodule
